pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_if.sv | 39 +++
 rtl/pwm_capture.sv | 186 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Measurement port bundle for pwm_capture: the PWM input and enable go in,
// and the published duty, period, valid strobe and timeout level come out.
// The slave modport is the capture block; the master modport is its user.

`ifndef PWM_FREQ
`define PWM_FREQ 1000000
`endif
`ifndef PWM_RES
`define PWM_RES 8
`endif

interface pwm_capture_if #(
  parameter int NBITS = `PWM_RES
);
  logic             en;       // capture enable
  logic             in;       // asynchronous PWM input
  logic [NBITS-1:0] duty;     // last high time in ticks, saturated
  logic [NBITS:0]   period;   // last period in ticks
  logic             valid;    // one-cycle strobe on every publish
  logic             timeout;  // level: input signal lost

  modport master (
    output en,
    output in,
    input  duty,
    input  period,
    input  valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  in,
    output duty,
    output period,
    output valid,
    output timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM input, measures its high time
// and period in prescaled ticks (FREQ*2^NBITS per second), and publishes the
// pair on each rising edge after a complete pulse. Loss of edges for TMO ticks
// publishes a timeout instead. The first partial pulse after reset, enable or
// timeout is always discarded.

`ifndef PWM_FREQ
`define PWM_FREQ 1000000
`endif
`ifndef PWM_RES
`define PWM_RES 8
`endif

module pwm_capture #(
  parameter int CLK_FREQ = 48000000,
  parameter int FREQ     = `PWM_FREQ,
  parameter int NBITS    = `PWM_RES
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  // Prescaler terminal count: one tick every DIV+1 clocks.
  localparam int DIV = CLK_FREQ / (FREQ * (2 ** NBITS)) - 1;
  localparam int PW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  // Counters need one bit beyond the period width to reach TMO.
  localparam int CW  = NBITS + 2;

  localparam logic [PW-1:0]  DIV_V     = PW'((DIV > 0) ? DIV : 0);
  localparam logic [CW-1:0]  TMO       = CW'(2 ** (NBITS + 1));
  localparam logic [CW-1:0]  TMO_LAST  = CW'(2 ** (NBITS + 1) - 1);
  localparam logic [CW-1:0]  HCNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]  DUTY_CAP  = CW'(2 ** NBITS - 1);
  localparam logic [CW-1:0]  PER_CAP   = CW'(2 ** (NBITS + 1) - 1);
  localparam logic [NBITS-1:0] DUTY_MAX = {NBITS{1'b1}};

  // A clock too slow for the requested tick rate cannot be built.
  if (DIV < 0) begin : g_div_check
    $fatal(1, "pwm_capture: CLK_FREQ %0d too low for FREQ %0d at %0d bits (DIV < 0)",
           CLK_FREQ, FREQ, NBITS);
  end

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state, state_n;

  logic s1, s2, s3;
  logic rise, fall;
  logic [PW-1:0] pre;
  logic tick;
  logic [CW-1:0] hcnt, pcnt;
  logic to_hit;
  logic publish, expire, clr_cnt;
  logic [CW-1:0] per_sum;
  logic [NBITS-1:0] duty_pub;
  logic [NBITS:0] period_pub;

  logic [NBITS-1:0] duty_q;
  logic [NBITS:0]   period_q;
  logic             valid_q;
  logic             timeout_q;

  // Two-flop synchronizer plus one delay flop for edge detection; runs regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
      // blocking here would collapse the chain into a single flop.
      s1 <= bus.in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Prescaler: counts 0..DIV while enabled, restarts on every rise so ticks are phase-locked to the input.
  always_ff @(posedge clk) begin
    if (rst || !bus.en || rise) begin
      pre <= '0;
    end else if (pre == DIV_V) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick   = bus.en & (pre == DIV_V);
  assign to_hit = tick & (pcnt == TMO_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state and control strobes; a rise outranks a coincident timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n = state;
    publish = 1'b0;
    expire  = 1'b0;
    clr_cnt = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
    end else if (rise) begin
      case (state)
        IDLE: begin
          state_n = HIGH;
          clr_cnt = 1'b1;
        end
        LOW: begin
          state_n = HIGH;
          clr_cnt = 1'b1;
          publish = 1'b1;
        end
        default: ;  // a rise while HIGH cannot occur
      endcase
    end else if (to_hit) begin
      state_n = IDLE;
      expire  = 1'b1;
    end else if (fall && state == HIGH) begin
      state_n = LOW;
    end
  end

  // High-time and period counters; both saturate, pcnt parks at TMO after a timeout.
  always_ff @(posedge clk) begin
    if (rst || !bus.en || clr_cnt) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (tick) begin
      if (pcnt != TMO) begin
        pcnt <= pcnt + CW'(1);
      end
      if (state == HIGH && hcnt != HCNT_MAX) begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  // The rise cycle's own tick closes the period, matching how the fall cycle's tick closes the high time.
  assign per_sum    = pcnt + CW'(tick);
  assign period_pub = (per_sum > PER_CAP) ? PER_CAP[NBITS:0] : per_sum[NBITS:0];
  assign duty_pub   = (hcnt > DUTY_CAP) ? DUTY_MAX : hcnt[NBITS-1:0];

  // Published results: valid pulses one cycle per publish or timeout; values hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= publish | expire;
      if (publish) begin
        duty_q    <= duty_pub;
        period_q  <= period_pub;
        timeout_q <= 1'b0;
      end else if (expire) begin
        duty_q    <= s2 ? DUTY_MAX : '0;
        period_q  <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.duty    = duty_q;
  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. A timestamp-based model predicts the
// outputs each cycle; a compare process checks them on every falling edge,
// and directed scenarios pin both DUT and model to hand-computed values.
`timescale 1ns/1ps

module tb_pwm_capture;

  localparam int CLK_FREQ = 48000000;
  localparam int FREQ     = 1000000;
  localparam int NBITS    = 4;
  localparam int DIVP1    = CLK_FREQ / (FREQ * (2 ** NBITS));   // clocks per tick
  localparam int TMO_CYC  = (2 ** (NBITS + 1)) * DIVP1;         // clocks to timeout
  localparam int DMAX     = 2 ** NBITS - 1;
  localparam int PMAX     = 2 ** (NBITS + 1) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_capture_if #(.NBITS(NBITS)) bus ();

  pwm_capture #(
    .CLK_FREQ(CLK_FREQ),
    .FREQ    (FREQ),
    .NBITS   (NBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timestamps instead of counters: ticks fall every DIVP1 clocks after the
  // last prescaler restart, so tick counts are plain divisions of cycle gaps.
  int  cyc = 0;
  bit  m_s1, m_s2, m_s3;
  bit  active, have_fall;
  int  t_start, t_fall, last_clear;
  int  exp_duty, exp_period;
  bit  exp_valid, exp_timeout;
  bit  model_live = 1'b0;

  always @(posedge clk) begin : model
    bit r, f;
    r = m_s2 && !m_s3;
    f = !m_s2 && m_s3;
    exp_valid = 1'b0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      active = 0; have_fall = 0;
      last_clear = cyc;
      exp_duty = 0; exp_period = 0; exp_timeout = 0;
      model_live = 1'b1;
    end else begin
      if (!bus.en) begin
        active = 0;
        last_clear = cyc;
      end else if (r) begin
        if (active && have_fall) begin
          exp_duty    = ((t_fall - t_start) / DIVP1 > DMAX) ? DMAX : (t_fall - t_start) / DIVP1;
          exp_period  = ((cyc - t_start) / DIVP1 > PMAX) ? PMAX : (cyc - t_start) / DIVP1;
          exp_timeout = 0;
          exp_valid   = 1;
        end
        active = 1; have_fall = 0;
        t_start = cyc; last_clear = cyc;
      end else if (cyc - last_clear == TMO_CYC) begin
        exp_duty    = m_s2 ? DMAX : 0;
        exp_period  = 0;
        exp_timeout = 1;
        exp_valid   = 1;
        active = 0;
      end else if (f && active && !have_fall) begin
        have_fall = 1;
        t_fall = cyc;
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.in;
    end
    cyc++;
  end

  // ---------------- compare process ----------------
  int vcount = 0;
  int last_duty, last_period, last_timeout;

  always @(negedge clk) begin
    if (model_live) begin
      check("valid",   int'(bus.valid),   int'(exp_valid));
      check("duty",    int'(bus.duty),    exp_duty);
      check("period",  int'(bus.period),  exp_period);
      check("timeout", int'(bus.timeout), int'(exp_timeout));
      if (bus.valid) begin
        vcount++;
        last_duty    = int'(bus.duty);
        last_period  = int'(bus.period);
        last_timeout = int'(bus.timeout);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in = 1'b1;
      cycles(hi);
      bus.in = 1'b0;
      cycles(per - hi);
    end
  endtask

  int vc0;

  initial begin
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.in = 1'b1;
    @(negedge clk);
    bus.in = 1'b0;
    @(negedge clk);
    check("rst_duty",    int'(bus.duty),    0);
    check("rst_period",  int'(bus.period),  0);
    check("rst_valid",   int'(bus.valid),   0);
    check("rst_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    cycles(4);

    // Nominal 48-clk period, 12 clk high: duty 4, period 16.
    vc0 = vcount;
    pulse(48, 12, 1);
    check("first_rise_no_valid", vcount - vc0, 0);
    pulse(48, 12, 3);
    check("nominal_valid_count", vcount - vc0, 3);
    check("nominal_duty",        last_duty, 4);
    check("nominal_period",      last_period, 16);
    check("nominal_timeout",     last_timeout, 0);
    check("model_nominal_duty",  exp_duty, 4);
    check("model_nominal_period", exp_period, 16);

    // Input lost low: exactly one timeout publish.
    vc0 = vcount;
    cycles(150);
    check("lost_low_valid_count", vcount - vc0, 1);
    check("lost_low_timeout",     last_timeout, 1);
    check("lost_low_duty",        last_duty, 0);
    check("lost_low_period",      last_period, 0);
    cycles(100);
    check("lost_low_no_repeat",   vcount - vc0, 1);

    // Restart: timeout clears at the second rise.
    vc0 = vcount;
    pulse(48, 12, 1);
    check("restart_first_rise", vcount - vc0, 0);
    pulse(48, 12, 1);
    check("restart_valid_count", vcount - vc0, 1);
    check("restart_timeout",     last_timeout, 0);
    check("restart_duty",        last_duty, 4);

    // 60-clk period, 54 high: duty saturates at 15, period 20.
    pulse(60, 54, 3);
    check("sat_duty",       last_duty, 15);
    check("sat_period",     last_period, 20);
    check("model_sat_duty", exp_duty, 15);

    // Input stuck high: one normal publish at the rise, then a timeout with duty 15.
    vc0 = vcount;
    bus.in = 1'b1;
    cycles(150);
    check("stuck_high_valid_count", vcount - vc0, 2);
    check("stuck_high_timeout",     last_timeout, 1);
    check("stuck_high_duty",        last_duty, 15);
    check("stuck_high_period",      last_period, 0);
    bus.in = 1'b0;
    cycles(10);

    // Reset mid-HIGH discards the measurement; valid only at the second rise.
    pulse(48, 12, 2);
    bus.in = 1'b1;
    cycles(6);
    rst = 1'b1;
    cycles(2);
    bus.in = 1'b0;
    rst = 1'b0;
    cycles(20);
    vc0 = vcount;
    pulse(48, 12, 1);
    check("post_rst_first_rise", vcount - vc0, 0);
    pulse(48, 12, 1);
    check("post_rst_valid_count", vcount - vc0, 1);
    check("post_rst_duty",        last_duty, 4);
    check("post_rst_period",      last_period, 16);

    // Enable dropped mid-LOW: outputs hold, no valid, two rises needed after.
    pulse(48, 12, 2);
    bus.in = 1'b1;
    cycles(12);
    bus.in = 1'b0;
    cycles(20);
    vc0 = vcount;
    bus.en = 1'b0;
    cycles(10);
    check("en_low_no_valid",    vcount - vc0, 0);
    check("en_low_duty_hold",   int'(bus.duty), 4);
    check("en_low_period_hold", int'(bus.period), 16);
    bus.en = 1'b1;
    cycles(6);
    pulse(48, 12, 1);
    check("reenable_first_rise", vcount - vc0, 0);
    pulse(48, 12, 1);
    check("reenable_valid_count", vcount - vc0, 1);

    // Randomized pulses with occasional enable drops and resets.
    for (int i = 0; i < 80; i++) begin
      int per, hi;
      per = int'($urandom_range(4, 140));
      hi  = int'($urandom_range(1, per - 1));
      pulse(per, hi, 1);
      if ($urandom_range(0, 9) == 0) begin
        bus.en = 1'b0;
        cycles(int'($urandom_range(1, 20)));
        bus.en = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        cycles(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
    end

    cycles(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
